// File: rtl/uart_echo_responder.sv
// -----------------------------------------------------------------------------
// uart_echo_responder
//
// Device-side responder of an 8N1 UART link. Bytes arriving on rxSerial are
// deserialized. Each byte with a good stop bit is queued in a small FIFO and
// retransmitted on txSerial. This block is also the loopback target used
// during link bring-up.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit, both directions (>= 4)
//   FIFO_DEPTH    echo buffer entries (power of two, >= 2)
//
// Ports:
//   iclk         clock; all logic runs on the rising edge
//   irst         synchronous, active-high reset
//   rxSerial     serial input; idles high; asynchronous to iclk
//   txHold       when high, no new TX frame starts
//   txSerial     serial output; idles high
//   txActive     high from the first start-bit cycle to the last stop-bit cycle
//   rxDataValid  one-cycle pulse: good byte received
//   rxByte       last good received byte (raw); held until the next good byte
//   frameErr     one-cycle pulse: stop bit sampled low
//   overflow     one-cycle pulse: good byte dropped because the FIFO was full
//   fifoCount    current FIFO occupancy
//
// Optional feature macro: UART_ECHO_UPCASE_EN
//   When defined, bytes 8'h61..8'h7A are converted to upper case before they
//   enter the FIFO. rxByte always shows the raw byte.
// -----------------------------------------------------------------------------
module uart_echo_responder #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic                          rxSerial,
  input  logic                          txHold,
  output logic                          txSerial,
  output logic                          txActive,
  output logic                          rxDataValid,
  output logic [7:0]                    rxByte,
  output logic                          frameErr,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [CW-1:0]    BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer. The flops reset high so that no false start bit is
  // seen when reset is released.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  // NOTE: clocked state is always written with non-blocking (<=) assignments so
  // every flop samples the pre-edge values; combinational blocks use blocking.
  always_ff @(posedge iclk) begin
    if (irst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rxSerial};
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // FIFO control signals. These are shared by the RX and TX sides.
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       push_data;
  logic             push, pop, full_next;

  state_e tx_state_q, tx_state_d;

  // The TX side pops only from IDLE, so txHold cannot cut a frame short.
  assign pop = (tx_state_q == S_IDLE) && (count_q != '0) && !txHold;
  // A good byte is decided one cycle before its push. This term therefore
  // accounts for a pop that happens in the same cycle as that decision.
  assign full_next = (count_q == FULL_CNT) && !pop;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;

  // NOTE: every signal driven here gets a default value first. As a result
  // no path leaves one unassigned, and no latch is inferred.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        if (!rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        // Resample at the start-bit midpoint. If the line is high here, the
        // low level was a glitch.
        if (rx_cnt_q == HALF_BIT) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = '0;
          if (rx_s) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            overflow_d = full_next;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO. The push comes from the registered valid pulse, so the byte is
  // stored at the end of the cycle in which rxDataValid is high.
  // ---------------------------------------------------------------------------
  assign push = rx_valid_q && !overflow_q;

`ifdef UART_ECHO_UPCASE_EN
  always_comb begin
    if (rx_byte_q inside {[8'h61:8'h7A]}) push_data = rx_byte_q - 8'h20;
    else                                  push_data = rx_byte_q;
  end
`else
  assign push_data = rx_byte_q;
`endif

  // NOTE: the storage array has no reset. Only the pointers and the count
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge iclk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM. The line outputs are registered from the next-state values. This
  // keeps txSerial glitch-free and aligned with the state change.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_serial_q, tx_serial_d;
  logic          tx_active_q, tx_active_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      S_IDLE: begin
        if (pop) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_shift_d = mem_q[rptr_q];
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Returning to IDLE forces at least one idle-high cycle between frames.
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    unique case (tx_state_d)
      S_START: tx_serial_d = 1'b0;
      S_DATA:  tx_serial_d = tx_shift_d[0];
      default: tx_serial_d = 1'b1;
    endcase
    tx_active_d = (tx_state_d != S_IDLE);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign txSerial    = tx_serial_q;
  assign txActive    = tx_active_q;
  assign rxDataValid = rx_valid_q;
  assign rxByte      = rx_byte_q;
  assign frameErr    = frame_err_q;
  assign overflow    = overflow_q;
  assign fifoCount   = count_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_responder
//
// Directed bench for uart_echo_responder (CLKS_PER_BIT=217, FIFO_DEPTH=4).
// A serial driver generates 8N1 frames on rxSerial. Background monitors count
// the status pulses and decode the echoed frames on txSerial. Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_echo_responder;

  localparam int C     = 217;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       rxSerial = 1'b1;
  logic       txHold = 1'b0;
  logic       txSerial, txActive, rxDataValid, frameErr, overflow;
  logic [7:0] rxByte;
  logic [$clog2(DEPTH):0] fifoCount;

  uart_echo_responder #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .iclk        (iclk),
    .irst        (irst),
    .rxSerial    (rxSerial),
    .txHold      (txHold),
    .txSerial    (txSerial),
    .txActive    (txActive),
    .rxDataValid (rxDataValid),
    .rxByte      (rxByte),
    .frameErr    (frameErr),
    .overflow    (overflow),
    .fifoCount   (fifoCount)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int rv_cnt = 0, fe_cnt = 0, ov_cnt = 0, excl_viol = 0, stop_bad = 0;
  int last_rv_cyc = 0;
  int act_run = 0;
  int echo_q[$];
  int txs_q[$];
  int act_q[$];

  always @(negedge iclk) begin
    if (rxDataValid === 1'b1) begin
      rv_cnt++;
      last_rv_cyc = cyc;
    end
    if (frameErr === 1'b1) fe_cnt++;
    if (overflow === 1'b1) ov_cnt++;
    if (frameErr === 1'b1 && (rxDataValid === 1'b1 || overflow === 1'b1)) excl_viol++;
    if (overflow === 1'b1 && rxDataValid !== 1'b1) excl_viol++;
    if (txActive === 1'b1) act_run++;
    else if (act_run > 0) begin
      act_q.push_back(act_run);
      act_run = 0;
    end
  end

  // Echo decoder. It detects each falling edge and samples every bit
  // at its midpoint.
  initial begin : tx_dec
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    b    = '0;
    forever begin
      @(negedge iclk);
      if (txSerial === 1'b0 && prev === 1'b1 && irst === 1'b0) begin
        txs_q.push_back(cyc);
        repeat (C / 2) @(negedge iclk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge iclk);
          b[i] = txSerial;
        end
        repeat (C) @(negedge iclk);
        if (txSerial !== 1'b1) stop_bad++;
        echo_q.push_back(int'(b));
      end
      prev = txSerial;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge iclk); #1 rxSerial = 1'b0;
    repeat (C) @(posedge iclk);
    for (int i = 0; i < 8; i++) begin
      #1 rxSerial = b[i];
      repeat (C) @(posedge iclk);
    end
    #1 rxSerial = stop;
    repeat (C) @(posedge iclk);
    #1 rxSerial = 1'b1;
  endtask

  task automatic clear_logs();
    echo_q.delete();
    txs_q.delete();
    act_q.delete();
  endtask

  // Waits, with a bound, for n decoded echoes and then lets the frame end.
  task automatic wait_echo(input string tag, input int n);
    int budget;
    budget = n * 12 * C + 4 * C;
    while (echo_q.size() < n && budget > 0) begin
      @(negedge iclk);
      budget--;
    end
    check(tag, echo_q.size(), n);
    repeat (C + 4) @(negedge iclk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int rv0, fe0, ov0, hold_cyc, s, budget;
    logic [7:0] up_exp;

    // Reset state
    repeat (2) @(negedge iclk);
    check("rst_txSerial", txSerial, 1);
    check("rst_txActive", txActive, 0);
    check("rst_rxDataValid", rxDataValid, 0);
    check("rst_frameErr", frameErr, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rxByte", rxByte, 8'h00);
    check("rst_fifoCount", fifoCount, 0);
    @(posedge iclk); #1 irst = 1'b0;
    repeat (5) @(posedge iclk);

    // Single byte echo
    clear_logs();
    rv0 = rv_cnt;
    send_byte(8'h3F, 1'b1);
    check("single_rv_count", rv_cnt - rv0, 1);
    check("single_rxByte", rxByte, 8'h3F);
    wait_echo("single_echo_n", 1);
    check("single_echo", (echo_q.size() > 0) ? echo_q[0] : -1, 8'h3F);
    check("single_latency", (txs_q.size() > 0) ? txs_q[0] - last_rv_cyc : -1, 2);
    check("single_active_len", (act_q.size() > 0) ? act_q[0] : -1, FRAME);
    check("single_fifo_empty", fifoCount, 0);

    // Glitch shorter than half a bit
    clear_logs();
    rv0 = rv_cnt; fe0 = fe_cnt;
    @(posedge iclk); #1 rxSerial = 1'b0;
    repeat (50) @(posedge iclk);
    #1 rxSerial = 1'b1;
    repeat (3 * C) @(negedge iclk);
    check("glitch_rv", rv_cnt - rv0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_txActive", act_q.size() + act_run, 0);

    // Framing error
    rv0 = rv_cnt; fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0);
    repeat (2 * C) @(negedge iclk);
    check("ferr_fe_count", fe_cnt - fe0, 1);
    check("ferr_rv_count", rv_cnt - rv0, 0);
    check("ferr_rxByte", rxByte, 8'h3F);
    check("ferr_fifoCount", fifoCount, 0);

    // Hold and overflow
    @(posedge iclk); #1 txHold = 1'b1;
    clear_logs();
    rv0 = rv_cnt; ov0 = ov_cnt;
    for (int b = 1; b <= 6; b++) send_byte(8'(b), 1'b1);
    repeat (C) @(negedge iclk);
    check("hold_fifoCount_full", fifoCount, 4);
    check("hold_overflow_count", ov_cnt - ov0, 2);
    check("hold_rv_count", rv_cnt - rv0, 6);
    check("hold_no_tx", echo_q.size() + act_q.size() + act_run, 0);
    check("hold_rxByte", rxByte, 8'h06);
    @(posedge iclk); #1 txHold = 1'b0;
    hold_cyc = cyc;
    wait_echo("hold_echo_n", 4);
    check("hold_release_start", (txs_q.size() > 0) ? txs_q[0] - hold_cyc : -1, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_echo_%0d", i), (echo_q.size() > i) ? echo_q[i] : -1, i + 1);
      check($sformatf("hold_active_len_%0d", i), (act_q.size() > i) ? act_q[i] : -1, FRAME);
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("hold_gap_%0d", i),
            (txs_q.size() > i + 1) ? txs_q[i + 1] - txs_q[i] : -1, FRAME + 1);
    check("hold_fifo_drained", fifoCount, 0);

    // Reset during echo data bit 3
    clear_logs();
    send_byte(8'hC3, 1'b1);
    budget = 4 * C;
    while (txs_q.size() == 0 && budget > 0) begin
      @(negedge iclk);
      budget--;
    end
    check("rstmid_tx_started", txs_q.size(), 1);
    s = (txs_q.size() > 0) ? txs_q[0] : cyc;
    while (cyc < s + 4 * C + 50) @(posedge iclk);
    #1 irst = 1'b1;
    @(posedge iclk); #1 irst = 1'b0;
    @(negedge iclk);
    check("rstmid_txSerial", txSerial, 1);
    check("rstmid_txActive", txActive, 0);
    check("rstmid_fifoCount", fifoCount, 0);
    repeat (8 * C) @(negedge iclk);
    clear_logs();
    send_byte(8'h55, 1'b1);
    check("rstmid_rxByte", rxByte, 8'h55);
    wait_echo("rstmid_echo_n", 1);
    check("rstmid_echo", (echo_q.size() > 0) ? echo_q[0] : -1, 8'h55);
    check("rstmid_active_len", (act_q.size() > 0) ? act_q[0] : -1, FRAME);

    // Case conversion (build-dependent)
`ifdef UART_ECHO_UPCASE_EN
    up_exp = 8'h41;
`else
    up_exp = 8'h61;
`endif
    clear_logs();
    send_byte(8'h61, 1'b1);
    check("case_rxByte_61", rxByte, 8'h61);
    send_byte(8'h3F, 1'b1);
    check("case_rxByte_3f", rxByte, 8'h3F);
    wait_echo("case_echo_n", 2);
    check("case_echo_0", (echo_q.size() > 0) ? echo_q[0] : -1, up_exp);
    check("case_echo_1", (echo_q.size() > 1) ? echo_q[1] : -1, 8'h3F);

    check("pulse_exclusive", excl_viol, 0);
    check("tx_stop_bits", stop_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
